// File: rtl/dcache_responder_if.sv
// Memory-side bus of the data cache: single-word requests, one outstanding at a time.
//   master (cache)  : drives mem_req/mem_we/mem_addr/mem_wdata/mem_wmask, receives mem_ack/mem_rdata
//   slave  (memory) : the mirror image
// mem_req is held until the 1-cycle mem_ack; mem_rdata is valid with mem_ack.
interface dcache_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dcache_read/_addr        demand read, held until dcache_read_done
//   dcache_read_done/_data   combinational hit response (same cycle)
//   dcache_prefetch/_pre_addr prefetch hint, sampled every cycle into a 1-entry buffer
//   st_valid/_addr/_data/_mask committed store, held until st_ready
//   st_ready                 pulses in the cycle the memory acknowledges the store write
//   mem_bus                  single-word memory request bus (master side)
// Stores win over reads; read misses win over pending prefetches. Misses refill a
// whole line with four sequential word reads; stores write through and only update
// the cache when they hit.
module dcache_responder #(
    parameter int unsigned LINES  = 16,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              dcache_read,
    input  logic [ADDR_W-1:0] dcache_read_addr,
    output logic              dcache_read_done,
    output logic [DATA_W-1:0] dcache_read_data,

    input  logic              dcache_prefetch,
    input  logic [ADDR_W-1:0] dcache_pre_addr,

    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [3:0]        st_mask,
    output logic              st_ready,

    dcache_responder_if.master mem_bus
);

    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = ADDR_W - 4 - IDX_W;
    localparam int unsigned LINE_W = ADDR_W - 4;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned NBYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2
    } state_e;

    // FSM and control registers
    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [LINE_W-1:0]   refill_line_q, refill_line_d;
    logic                pf_valid_q, pf_valid_d;
    logic [LINE_W-1:0]   pf_line_q, pf_line_d;
    logic [LINES-1:0]    valid_q, valid_d;

    // registered memory-bus outputs
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_wmask_q, mem_wmask_d;

    // tag and data storage (no reset; qualified by valid_q)
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES][WORDS];

    // storage write ports driven by the next-state logic
    logic                tag_we;
    logic                data_we;
    logic [IDX_W-1:0]    data_widx;
    logic [1:0]          data_woff;
    logic [DATA_W-1:0]   data_wval;

    logic                start_refill;
    logic [LINE_W-1:0]   start_line;
    logic [DATA_W-1:0]   st_merged;

    // address decode for the three lookup ports
    logic [IDX_W-1:0]    rd_idx, pf_idx, st_idx, rf_idx;
    logic [1:0]          rd_off, st_off;
    logic                rd_hit, pf_hit, st_hit;

    assign rd_idx = dcache_read_addr[4 +: IDX_W];
    assign rd_off = dcache_read_addr[3:2];
    assign st_idx = st_addr[4 +: IDX_W];
    assign st_off = st_addr[3:2];
    assign pf_idx = pf_line_q[0 +: IDX_W];
    assign rf_idx = refill_line_q[0 +: IDX_W];

    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == dcache_read_addr[ADDR_W-1 -: TAG_W]);
    assign st_hit = valid_q[st_idx] && (tag_q[st_idx] == st_addr[ADDR_W-1 -: TAG_W]);
    assign pf_hit = valid_q[pf_idx] && (tag_q[pf_idx] == pf_line_q[LINE_W-1 -: TAG_W]);

    // byte-offset and sub-word bits that never select anything
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dcache_read_addr[1:0], st_addr[1:0], dcache_pre_addr[3:0]};

    // hit path: fully combinational, blocked while a store is waiting
    assign dcache_read_done = dcache_read && rd_hit && (state_q == S_IDLE) && !st_valid;
    assign dcache_read_data = data_q[rd_idx][rd_off];

    // store acceptance coincides with the memory write acknowledge
    assign st_ready = (state_q == S_WRITE) && mem_bus.mem_ack;

    assign mem_bus.mem_req   = mem_req_q;
    assign mem_bus.mem_we    = mem_we_q;
    assign mem_bus.mem_addr  = mem_addr_q;
    assign mem_bus.mem_wdata = mem_wdata_q;
    assign mem_bus.mem_wmask = mem_wmask_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            refill_line_q <= '0;
            pf_valid_q    <= 1'b0;
            pf_line_q     <= '0;
            valid_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wmask_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            refill_line_q <= refill_line_d;
            pf_valid_q    <= pf_valid_d;
            pf_line_q     <= pf_line_d;
            valid_q       <= valid_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wmask_q   <= mem_wmask_d;
        end
    end

    // tag/data arrays; writes suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (!rst && tag_we) begin
            tag_q[rf_idx] <= refill_line_q[LINE_W-1 -: TAG_W];
        end
        if (!rst && data_we) begin
            data_q[data_widx][data_woff] <= data_wval;
        end
    end

    // next-state and storage-update logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        refill_line_d = refill_line_q;
        pf_valid_d    = pf_valid_q;
        pf_line_d     = pf_line_q;
        valid_d       = valid_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmask_d   = mem_wmask_q;
        tag_we        = 1'b0;
        data_we       = 1'b0;
        data_widx     = '0;
        data_woff     = '0;
        data_wval     = '0;
        start_refill  = 1'b0;
        start_line    = '0;

        // store data merged byte-wise into the currently cached word
        st_merged = data_q[st_idx][st_off];
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (st_mask[b]) begin
                st_merged[8*b +: 8] = st_data[8*b +: 8];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (st_valid) begin
                    state_d     = S_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = st_data;
                    mem_wmask_d = st_mask;
                end else if (dcache_read && !rd_hit) begin
                    start_refill = 1'b1;
                    start_line   = dcache_read_addr[ADDR_W-1:4];
                end else if (pf_valid_q && !pf_hit) begin
                    start_refill = 1'b1;
                    start_line   = pf_line_q;
                    pf_valid_d   = 1'b0;
                end
            end

            S_REFILL: begin
                if (mem_bus.mem_ack) begin
                    data_we   = 1'b1;
                    data_widx = rf_idx;
                    data_woff = cnt_q;
                    data_wval = mem_bus.mem_rdata;
                    if (cnt_q == 2'd3) begin
                        state_d         = S_IDLE;
                        cnt_d           = '0;
                        mem_req_d       = 1'b0;
                        tag_we          = 1'b1;
                        valid_d[rf_idx] = 1'b1;
                    end else begin
                        cnt_d      = 2'(cnt_q + 2'd1);
                        mem_addr_d = {refill_line_q, 2'(cnt_q + 2'd1), 2'b00};
                    end
                end
            end

            S_WRITE: begin
                if (mem_bus.mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (st_hit) begin
                        data_we   = 1'b1;
                        data_widx = st_idx;
                        data_woff = st_off;
                        data_wval = st_merged;
                    end
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        // line is invalid for the whole refill so a reset mid-way leaves it empty
        if (start_refill) begin
            state_d       = S_REFILL;
            cnt_d         = '0;
            refill_line_d = start_line;
            mem_req_d     = 1'b1;
            mem_we_d      = 1'b0;
            mem_addr_d    = {start_line, 4'b0000};
            valid_d[start_line[0 +: IDX_W]] = 1'b0;
        end

        // a pending prefetch that already hits needs no refill
        if ((state_q == S_IDLE) && pf_valid_q && pf_hit) begin
            pf_valid_d = 1'b0;
        end

        // newest prefetch wins, except one for the line being refilled right now
        if (dcache_prefetch &&
            !((state_q == S_REFILL) && (dcache_pre_addr[ADDR_W-1:4] == refill_line_q))) begin
            pf_valid_d = 1'b1;
            pf_line_d  = dcache_pre_addr[ADDR_W-1:4];
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: cold refill, hits, store merge, prefetch,
// store miss without allocation, conflict eviction and reset during a refill.
module tb_dcache_responder;

    localparam int unsigned LINES  = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              dcache_read;
    logic [ADDR_W-1:0] dcache_read_addr;
    logic              dcache_read_done;
    logic [DATA_W-1:0] dcache_read_data;
    logic              dcache_prefetch;
    logic [ADDR_W-1:0] dcache_pre_addr;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [3:0]        st_mask;
    logic              st_ready;

    dcache_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dcache_responder #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .dcache_read      (dcache_read),
        .dcache_read_addr (dcache_read_addr),
        .dcache_read_done (dcache_read_done),
        .dcache_read_data (dcache_read_data),
        .dcache_prefetch  (dcache_prefetch),
        .dcache_pre_addr  (dcache_pre_addr),
        .st_valid         (st_valid),
        .st_addr          (st_addr),
        .st_data          (st_data),
        .st_mask          (st_mask),
        .st_ready         (st_ready),
        .mem_bus          (bus.master)
    );

    always #5 clk = ~clk;

    // memory model: ack one cycle after seeing a request, never two cycles in a row
    logic [31:0] mem_arr [1024];
    logic [31:0] rd_log  [64];
    logic        mem_ack_r   = 1'b0;
    logic [31:0] mem_rdata_r = '0;
    int          rd_cnt      = 0;

    assign bus.mem_ack   = mem_ack_r;
    assign bus.mem_rdata = mem_rdata_r;

    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'hDA7A_0000 | 32'(i * 4);
    end

    always @(posedge clk) begin
        if (mem_ack_r) begin
            mem_ack_r <= 1'b0;
        end else if (bus.mem_req) begin
            mem_ack_r <= 1'b1;
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wmask[b])
                        mem_arr[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                mem_rdata_r         <= mem_arr[bus.mem_addr[11:2]];
                rd_log[6'(rd_cnt)]  <= bus.mem_addr;
                rd_cnt              <= rd_cnt + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // lat = cycles from request to done (0 = same-cycle hit), -1 on timeout
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(posedge clk); #1;
        dcache_read      = 1'b1;
        dcache_read_addr = a;
        lat = -1;
        d   = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dcache_read_done) begin
                d   = dcache_read_data;
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
        dcache_read = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            output logic [3:0] wm, output logic [31:0] wa, output int lat);
        @(posedge clk); #1;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_mask  = m;
        lat = -1;
        wm  = '0;
        wa  = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (st_ready) begin
                wm  = bus.mem_wmask;
                wa  = bus.mem_addr;
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] wa;
        logic [3:0]  wm;
        int          lat;
        int          base;
        logic        seen;

        rst = 1'b1;
        dcache_read = 1'b0;     dcache_read_addr = '0;
        dcache_prefetch = 1'b0; dcache_pre_addr = '0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_req",   32'(bus.mem_req),   32'd0);
        check_eq("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check_eq("rst_mem_addr",  bus.mem_addr,       32'd0);
        check_eq("rst_mem_wdata", bus.mem_wdata,      32'd0);
        check_eq("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        check_eq("rst_st_ready",  32'(st_ready),      32'd0);
        check_eq("rst_done",      32'(dcache_read_done), 32'd0);

        // cold miss: four word reads, done 9 cycles after the request
        base = rd_cnt;
        do_read(32'h100, d, lat);
        check_eq("cold_data",  d,                    32'hDA7A_0100);
        check_eq("cold_lat",   32'(lat),             32'd9);
        check_eq("cold_nrd",   32'(rd_cnt - base),   32'd4);
        check_eq("cold_addr0", rd_log[6'(base)],     32'h100);
        check_eq("cold_addr3", rd_log[6'(base + 3)], 32'h10C);

        // hit in the same line: same cycle, no memory traffic
        base = rd_cnt;
        do_read(32'h108, d, lat);
        check_eq("hit_data", d,                  32'hDA7A_0108);
        check_eq("hit_lat",  32'(lat),           32'd0);
        check_eq("hit_nrd",  32'(rd_cnt - base), 32'd0);
        check_eq("hit_req",  32'(bus.mem_req),   32'd0);

        // store hit: write-through with mask, merged word visible to the next read
        do_store(32'h104, 32'h0000_AB00, 4'b0010, wm, wa, lat);
        check_eq("sth_wmask", 32'(wm),  32'h2);
        check_eq("sth_waddr", wa,       32'h104);
        check_eq("sth_lat",   32'(lat), 32'd2);
        check_eq("sth_mem",   mem_arr[65], 32'hDA7A_AB04);
        do_read(32'h104, d, lat);
        check_eq("sth_rd_data", d,        32'hDA7A_AB04);
        check_eq("sth_rd_lat",  32'(lat), 32'd0);

        // prefetch of 0x200 refills in the background; later read hits
        base = rd_cnt;
        @(posedge clk); #1;
        dcache_prefetch = 1'b1;
        dcache_pre_addr = 32'h200;
        @(posedge clk); #1;
        dcache_prefetch = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_cnt == base + 4) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("pf_refill", 32'(seen), 32'd1);
        check_eq("pf_addr0",  rd_log[6'(base)], 32'h200);
        @(posedge clk);
        base = rd_cnt;
        do_read(32'h204, d, lat);
        check_eq("pf_hit_data", d,                  32'hDA7A_0204);
        check_eq("pf_hit_lat",  32'(lat),           32'd0);
        check_eq("pf_hit_nrd",  32'(rd_cnt - base), 32'd0);

        // store miss: memory written, line not allocated
        do_store(32'h900, 32'h1122_3344, 4'b1111, wm, wa, lat);
        check_eq("stm_waddr", wa,       32'h900);
        check_eq("stm_lat",   32'(lat), 32'd2);
        base = rd_cnt;
        do_read(32'h900, d, lat);
        check_eq("stm_rd_lat",  32'(lat),           32'd9);
        check_eq("stm_rd_data", d,                  32'h1122_3344);
        check_eq("stm_rd_nrd",  32'(rd_cnt - base), 32'd4);

        // 0x100 and 0x200 share index 0 and evict each other
        do_read(32'h100, d, lat);
        check_eq("ev_a_lat", 32'(lat), 32'd9);
        do_read(32'h200, d, lat);
        check_eq("ev_b_lat",  32'(lat), 32'd9);
        check_eq("ev_b_data", d,        32'hDA7A_0200);
        base = rd_cnt;
        do_read(32'h100, d, lat);
        check_eq("ev_a2_lat",  32'(lat),           32'd9);
        check_eq("ev_a2_data", d,                  32'hDA7A_0100);
        check_eq("ev_a2_nrd",  32'(rd_cnt - base), 32'd4);

        // reset during the second refill acknowledge
        base = rd_cnt;
        @(posedge clk); #1;
        dcache_read      = 1'b1;
        dcache_read_addr = 32'h340;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_ack && (rd_cnt == base + 2)) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rstm_2nd_ack", 32'(seen), 32'd1);
        rst         = 1'b1;
        dcache_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstm_req", 32'(bus.mem_req), 32'd0);
        base = rd_cnt;
        do_read(32'h340, d, lat);
        check_eq("rstm_lat",   32'(lat),           32'd9);
        check_eq("rstm_data",  d,                  32'hDA7A_0340);
        check_eq("rstm_nrd",   32'(rd_cnt - base), 32'd4);
        check_eq("rstm_addr0", rd_log[6'(base)],   32'h340);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
